// File: rtl/pattern_write_arbiter_if.sv
// pattern_write_arbiter_if: request/grant handshakes of both requesters plus the field write port.
interface pattern_write_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              r0_valid;
    logic              r0_ready;
    logic [2:0]        r0_buf;
    logic [4:0]        r0_field;
    logic [DATA_W-1:0] r0_data;
    logic              r1_valid;
    logic              r1_ready;
    logic [2:0]        r1_buf;
    logic [4:0]        r1_field;
    logic [DATA_W-1:0] r1_data;
    logic [2:0]        wr_buf;
    logic [4:0]        wr_field;
    logic [DATA_W-1:0] wr_data;
    logic              wr_strobe;

    modport master (
        output r0_valid, r0_buf, r0_field, r0_data,
        output r1_valid, r1_buf, r1_field, r1_data,
        input  r0_ready, r1_ready, wr_buf, wr_field, wr_data, wr_strobe
    );

    modport slave (
        input  r0_valid, r0_buf, r0_field, r0_data,
        input  r1_valid, r1_buf, r1_field, r1_data,
        output r0_ready, r1_ready, wr_buf, wr_field, wr_data, wr_strobe
    );
endinterface

// File: rtl/pattern_write_arbiter.sv
// pattern_write_arbiter: pat-priority arbiter for the pattern-buffer field write port with host starvation guard.
// Defining PWA_WRITE_COUNT_EN adds per-requester strobed-write counters cnt0/cnt1.
module pattern_write_arbiter #(
    parameter int BUF_COUNT   = 8,
    parameter int FIELD_COUNT = 22,
    parameter int DATA_W      = 8,
    parameter int MAX_WAIT    = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pattern_write_arbiter_if.slave bus,
    input  logic [2:0]             active_buf,
    input  logic                   protect_en,
    input  logic                   err_clr,
    output logic                   err_range
`ifdef PWA_WRITE_COUNT_EN
    ,
    output logic [15:0]            cnt0,
    output logic [15:0]            cnt1
`endif
);
    typedef enum logic {PRIO, FORCE} state_t;

    state_t            state, state_nxt;
    logic              elig1, grant0, grant1, accept, bad;
    logic [7:0]        wait_cnt, wait_nxt;
    logic [2:0]        sel_buf;
    logic [4:0]        sel_field;
    logic [DATA_W-1:0] sel_data;

    assign elig1 = bus.r1_valid && !(protect_en && bus.r1_buf == active_buf);
    assign wait_nxt = (!bus.r1_valid || grant1) ? 8'd0 :
                      (elig1 && wait_cnt != 8'hFF) ? wait_cnt + 8'd1 : wait_cnt;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= PRIO;
        else          state <= state_nxt;

    // Force on the cycle the host's losing streak reaches MAX_WAIT, so its grant lands on the next one.
    always_comb
        state_nxt = (state == PRIO) ? ((wait_nxt == 8'(MAX_WAIT)) ? FORCE : PRIO)
                                    : ((grant1 || !bus.r1_valid) ? PRIO : FORCE);

    always_comb begin
        grant1 = elig1 && (state == FORCE || !bus.r0_valid);
        grant0 = bus.r0_valid && !grant1;
    end

    assign bus.r0_ready = grant0;
    assign bus.r1_ready = grant1;
    assign accept       = grant0 || grant1;
    assign sel_buf      = grant1 ? bus.r1_buf   : bus.r0_buf;
    assign sel_field    = grant1 ? bus.r1_field : bus.r0_field;
    assign sel_data     = grant1 ? bus.r1_data  : bus.r0_data;
    assign bad          = {1'b0, sel_buf} >= 4'(BUF_COUNT) || {1'b0, sel_field} >= 6'(FIELD_COUNT);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wait_cnt      <= '0;
            bus.wr_buf    <= '0;
            bus.wr_field  <= '0;
            bus.wr_data   <= '0;
            bus.wr_strobe <= 1'b0;
            err_range     <= 1'b0;
        end else begin
            wait_cnt      <= wait_nxt;
            bus.wr_strobe <= accept && !bad;
            if (accept && !bad) begin
                bus.wr_buf   <= sel_buf;
                bus.wr_field <= sel_field;
                bus.wr_data  <= sel_data;
            end
            err_range <= !err_clr && (err_range || (accept && bad));
        end

`ifdef PWA_WRITE_COUNT_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (err_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (accept && !bad) begin
            if (grant1) cnt1 <= cnt1 + 16'd1;
            else        cnt0 <= cnt0 + 16'd1;
        end
`endif
endmodule

// File: tb/tb_pattern_write_arbiter.sv
// tb_pattern_write_arbiter: directed and random stimulus against a policy-level model with a write scoreboard.
module tb_pattern_write_arbiter;
    localparam int MAX_WAIT = 15, FIELD_COUNT = 22, BUF_COUNT = 8;

    logic       clk = 0, reset_n = 0, protect_en = 0, err_clr = 0, err_range;
    logic [2:0] active_buf = 0;
`ifdef PWA_WRITE_COUNT_EN
    logic [15:0] cnt0, cnt1;
`endif
    int cnt_exp[2];

    pattern_write_arbiter_if bus ();

    pattern_write_arbiter dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .active_buf(active_buf),
        .protect_en(protect_en),
        .err_clr(err_clr),
        .err_range(err_range)
`ifdef PWA_WRITE_COUNT_EN
        ,
        .cnt0(cnt0),
        .cnt1(cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int b; int f; int d; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    int  cyc = 0, checks = 0, failures = 0, streak = 0, first_r1 = 0;
    bit  owed = 0, err_exp = 0, g0 = 0, g1 = 0, seen_r1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic req(input int n, input bit v, input int b, input int f, input int d);
        if (n == 0) begin
            bus.r0_valid = v; bus.r0_buf = 3'(b); bus.r0_field = 5'(f); bus.r0_data = 8'(d);
        end else begin
            bus.r1_valid = v; bus.r1_buf = 3'(b); bus.r1_field = 5'(f); bus.r1_data = 8'(d);
        end
    endtask

    // Host is owed the port after MAX_WAIT consecutive eligible-but-lost cycles.
    task automatic tick();
        bit e1, bad;
        int b, f, d;
        @(negedge clk);
        e1 = bus.r1_valid && !(protect_en && bus.r1_buf == active_buf);
        g1 = e1 && (owed || !bus.r0_valid);
        g0 = bus.r0_valid && !g1;
        seen_r1 = bus.r1_ready;
        chk("r0_ready", bus.r0_ready, g0);
        chk("r1_ready", bus.r1_ready, g1);
        chk("err_range", err_range, err_exp);
`ifdef PWA_WRITE_COUNT_EN
        chk("cnt0", cnt0, cnt_exp[0]);
        chk("cnt1", cnt1, cnt_exp[1]);
`endif
        bad = 0;
        if (g0 || g1) begin
            b = g1 ? bus.r1_buf : bus.r0_buf;
            f = g1 ? bus.r1_field : bus.r0_field;
            d = g1 ? bus.r1_data : bus.r0_data;
            bad = f >= FIELD_COUNT || b >= BUF_COUNT;
            if (!bad) exp_q.push_back('{cyc + 1, b, f, d});
        end
        err_exp = !err_clr && (err_exp || bad);
        if (err_clr) cnt_exp = '{0, 0};
        else if ((g0 || g1) && !bad) cnt_exp[g1] = (cnt_exp[g1] + 1) & 32'hFFFF;
        if (!bus.r1_valid || g1) begin
            streak = 0;
            owed = 0;
        end else begin
            if (e1) streak++;
            if (streak >= MAX_WAIT) owed = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        chk("rst_wr_strobe", bus.wr_strobe, 0);
        chk("rst_wr_buf", bus.wr_buf, 0);
        chk("rst_wr_field", bus.wr_field, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_err_range", err_range, 0);
        exp_q.delete();
        streak = 0; owed = 0; err_exp = 0; g0 = 0; g1 = 0;
        cnt_exp = '{0, 0};
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_strobe expected at cycle %0d buf=%0d field=%0d data=%0h, wr_strobe stayed low",
                     exp_q[0].cyc, exp_q[0].b, exp_q[0].f, exp_q[0].d);
            void'(exp_q.pop_front());
        end
        if (reset_n && bus.wr_strobe) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe at cycle %0d buf=%0d field=%0d data=%0h, expected none",
                         cyc, bus.wr_buf, bus.wr_field, bus.wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.b != int'(bus.wr_buf) || mon_e.f != int'(bus.wr_field)
                    || mon_e.d != int'(bus.wr_data)) begin
                    failures++;
                    $display("FAIL write actual cyc=%0d buf=%0d field=%0d data=%0h expected cyc=%0d buf=%0d field=%0d data=%0h",
                             cyc, bus.wr_buf, bus.wr_field, bus.wr_data, mon_e.cyc, mon_e.b, mon_e.f, mon_e.d);
                end
            end
        end
    end

    initial begin
        req(0, 0, 0, 0, 0);
        req(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        req(0, 1, 3, 5, 'hA5);
        tick();
        req(0, 0, 0, 0, 0);
        repeat (2) tick();

        req(0, 1, 1, 1, 'h11);
        req(1, 1, 6, 2, 'h22);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (seen_r1 && first_r1 == 0) first_r1 = i;
        end
        chk("starve_first_r1_grant", first_r1, 16);
        req(0, 0, 0, 0, 0);
        req(1, 0, 0, 0, 0);
        tick();

        protect_en = 1;
        active_buf = 2;
        req(1, 1, 2, 7, 'h5A);
        repeat (3) tick();
        active_buf = 4;
        tick();
        req(1, 0, 0, 0, 0);
        repeat (2) tick();
        protect_en = 0;

        req(1, 1, 5, 22, 'h77);
        tick();
        req(1, 0, 0, 0, 0);
        repeat (3) tick();
        err_clr = 1;
        req(1, 1, 0, 31, 'h01);
        tick();
        err_clr = 0;
        req(1, 0, 0, 0, 0);
        repeat (2) tick();

        for (int i = 0; i < 3; i++) begin
            req(0, 1, i, i + 10, 'h40 + i);
            tick();
        end
        req(0, 0, 0, 0, 0);
        req(1, 1, 1, 25, 'h99);
        tick();
        req(1, 0, 0, 0, 0);
        repeat (2) tick();
`ifdef PWA_WRITE_COUNT_EN
        chk("cnt0_directed", cnt0, 3);
        chk("cnt1_directed", cnt1, 0);
`endif

        req(0, 1, 1, 2, 'h3C);
        tick();
        chk("strobe_before_reset", bus.wr_strobe, 1);
        req(0, 0, 0, 0, 0);
        do_reset();
        tick();

        for (int i = 0; i < 600; i++) begin
            if (!bus.r0_valid || g0)
                req(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 23), $urandom_range(0, 255));
            if (!bus.r1_valid || g1)
                req(1, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 23), $urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) active_buf = 3'($urandom_range(0, 7));
            protect_en = $urandom_range(0, 3) == 0;
            err_clr = $urandom_range(0, 15) == 0;
            tick();
        end
        err_clr = 0;
        req(0, 0, 0, 0, 0);
        req(1, 0, 0, 0, 0);
        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
